// File: rtl/xor_checksum.sv
// rtl/xor_checksum.sv - word-wise XOR checksum over a valid/ready framed stream
//
// Accumulates the XOR of every WIDTH-bit word accepted on the input stream.
// When a frame ends, the block holds the result on the output handshake. A
// frame ends on in_last, or when MAX_LEN beats have been taken without
// in_last, which is reported as an overflow.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of the current frame and any pending result
//   in_valid   source has a word
//   in_ready   block accepts a word this cycle (low only while a result is held)
//   in_data    data word
//   in_last    final word of the frame, qualified by in_valid
//   out_valid  result available
//   out_ready  sink accepts the result
//   out_data   XOR of all words in the frame
//   out_parity reduction XOR of out_data
//   out_count  number of words in the frame
//   out_err    frame ended by MAX_LEN overflow rather than in_last
module xor_checksum #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] acc_x;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit_max;

  // The handshake outputs are decoded from registered state only, so there is
  // no combinational path from out_ready to in_ready.
  assign in_ready  = (state != S_DONE);
  assign out_valid = (state == S_DONE);

  assign acc_x   = acc ^ in_data;
  assign cnt_inc = cnt + CNT_W'(1);
  // cnt never passes MAX_LEN because reaching it forces the frame to end.
  assign hit_max = (cnt_inc == CNT_W'(MAX_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      cnt        <= '0;
      out_data   <= '0;
      out_parity <= 1'b0;
      out_count  <= '0;
      out_err    <= 1'b0;
    end else if (clear) begin
      // clear wins over a simultaneous beat or output handshake
      state      <= S_IDLE;
      acc        <= '0;
      cnt        <= '0;
      out_data   <= '0;
      out_parity <= 1'b0;
      out_count  <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (in_valid) begin
            acc <= acc_x;
            cnt <= cnt_inc;
            if (in_last || hit_max) begin
              state      <= S_DONE;
              out_data   <= acc_x;
              out_parity <= ^acc_x;
              out_count  <= cnt_inc;
              // in_last on the MAX_LEN-th beat is a clean end, not an overflow
              out_err    <= ~in_last;
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          // result registers keep their values after the handshake
          if (out_ready) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          acc   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/xor_checksum.md
Name: xor_checksum

Overview:
- Parametrised, sequential successor to the team's single-bit XOR gate.
- Accumulates a word-wise XOR checksum over a frame of WIDTH-bit words received on a valid/ready stream.
- At frame end it presents checksum, checksum parity, beat count and an overflow flag on a held output handshake.
- Sits between a data source and a checker/display stage in lab datapaths.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- MAX_LEN, 16, maximum beats per frame (>=1); reaching it without in_last forces frame end with error.
- CNT_W, $clog2(MAX_LEN+1), beat counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; discards the current frame and any pending result.
- in_valid  input  1  source has a word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  data word.
- in_last  input  1  final word of frame, qualified by in_valid.
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts the result.
- out_data  output  WIDTH  XOR of all accepted words in the frame.
- out_parity  output  1  reduction XOR of out_data.
- out_count  output  CNT_W  number of words in the frame.
- out_err  output  1  frame ended by MAX_LEN overflow, not in_last.

Behaviour:
- Beat accepted when in_valid && in_ready at a rising clk edge.
- FSM, registered: IDLE (acc=0, cnt=0), ACCUM (cnt>=1), DONE (result held).
- in_ready = (state != DONE). It comes from the registered state only, with no combinational path from out_ready.
- IDLE/ACCUM, accepted beat:
  - acc <= acc ^ in_data; cnt <= cnt+1.
  - If in_last, or cnt+1 == MAX_LEN: go to DONE.
  - Load out_data = acc ^ in_data, out_count = cnt+1, out_parity = ^(acc ^ in_data).
  - out_err = 1 only if in_last=0 and cnt+1 == MAX_LEN. in_last on the MAX_LEN-th beat gives out_err=0.
- IDLE, accepted beat without end: go to ACCUM. No accepted beat: stay.
- DONE: out_valid=1.
  - Outputs stay stable until out_ready=1.
  - On that edge, state goes to IDLE, acc=0, cnt=0, out_valid=0.
  - in_ready=1 on the following cycle; one bubble cycle between frames.
- Latency: out_valid asserts on the cycle after the final beat is accepted.
- out_data, out_parity, out_count and out_err are registered. They hold their last values after handshake until the next frame completes.
- Arithmetic: cnt never exceeds MAX_LEN. No wrap, because the overflow rule forces DONE.
- clear=1 at an edge, in any state: go to IDLE, acc=0, cnt=0, out_valid=0. Result registers are cleared to 0. clear takes priority over a simultaneous beat or output handshake.
- rst_n=0 (asynchronous, any time, including mid-frame or in DONE), immediately:
  - state IDLE, acc=0, cnt=0;
  - out_valid=0, out_data=0, out_parity=0, out_count=0, out_err=0;
  - in_ready=1 while in reset and after release.
- WIDTH=1 degenerates to a serial parity accumulator. MAX_LEN=1 makes every beat its own frame, with out_err=1 unless in_last=1.

Test Plan:
(WIDTH=8, MAX_LEN=4 unless noted.)
- Reset: hold rst_n=0, then release → all outputs 0 except in_ready=1. Assert rst_n=0 asynchronously while in DONE → out_valid drops at once, with no clock edge.
- Frame 0x3C, 0xA5, 0x0F (last on the third beat), out_ready=1 → one cycle later out_valid=1, out_data=0x96, out_parity=0, out_count=3, out_err=0. in_ready is 0 for exactly one cycle.
- Single-beat frame 0x01 with last → out_data=0x01, out_parity=1, out_count=1, out_err=0.
- Overflow: beats 0x11, 0x22, 0x44, 0x88, none with last → out_data=0xFF, out_parity=0, out_count=4, out_err=1. A further beat 0x55 with last, offered while in DONE, is not accepted.
- Backpressure: result pending, out_ready=0 for 3 cycles with in_valid=1 → outputs unchanged and in_ready=0 throughout. After out_ready=1, in_ready=1 on the next cycle.
- Abort: beats 0xAA, 0xBB, then clear=1 on the cycle a third beat is offered → that beat is dropped. Next frame 0x5A with last gives out_data=0x5A, out_count=1, out_err=0.
